// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, registered sync and blanked colour,
// per-frame start pulse and completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic [2:0] rin,
    input  logic [2:0] gin,
    input  logic [2:0] bin,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rout,
    output logic [2:0] gout,
    output logic [2:0] bout,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_cnt_nxt, v_cnt_nxt;
    logic             hsync_nxt, vsync_nxt;
    logic [2:0]       rout_nxt, gout_nxt, bout_nxt;
    logic             frame_start_nxt;
    logic [7:0]       frame_cnt_nxt;
    logic             video_on_c, h_wrap_c, h_act_c, v_act_c;

    assign hcount   = h_cnt;
    assign vcount   = v_cnt;
    assign video_on = video_on_c;

    // Stage-0 decode of the current raster position
    always_comb begin
        video_on_c = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        h_wrap_c   = (h_cnt >= H_LAST);
        h_act_c    = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
        v_act_c    = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);
    end

    // Next-state: everything holds unless a pixel advances; out-of-range counts fold to 0
    always_comb begin
        h_cnt_nxt       = h_cnt;
        v_cnt_nxt       = v_cnt;
        hsync_nxt       = hsync;
        vsync_nxt       = vsync;
        rout_nxt        = rout;
        gout_nxt        = gout;
        bout_nxt        = bout;
        frame_start_nxt = 1'b0;
        frame_cnt_nxt   = frame_cnt;
        if (pix_ce) begin
            h_cnt_nxt = h_wrap_c ? '0 : h_cnt + CNT_W'(1);
            if (h_wrap_c)
                v_cnt_nxt = (v_cnt >= V_LAST) ? '0 : v_cnt + CNT_W'(1);
            else if (v_cnt > V_LAST)
                v_cnt_nxt = '0;
            hsync_nxt       = h_act_c ? SYNC_POL : ~SYNC_POL;
            vsync_nxt       = v_act_c ? SYNC_POL : ~SYNC_POL;
            rout_nxt        = video_on_c ? rin : 3'b000;
            gout_nxt        = video_on_c ? gin : 3'b000;
            bout_nxt        = video_on_c ? bin : 3'b000;
            frame_start_nxt = (h_cnt == '0) && (v_cnt == '0);
            if ((h_cnt == H_LAST) && (v_cnt == V_LAST))
                frame_cnt_nxt = frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            rout        <= 3'b000;
            gout        <= 3'b000;
            bout        <= 3'b000;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            h_cnt       <= h_cnt_nxt;
            v_cnt       <= v_cnt_nxt;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            rout        <= rout_nxt;
            gout        <= gout_nxt;
            bout        <= bout_nxt;
            frame_start <= frame_start_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a reduced raster; expectations come from a
// linear pixel-index model of the frame.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic POL = 1'b0;

    logic       vga_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       pix_ce  = 1'b0;
    logic [2:0] rin = '0, gin = '0, bin = '0;
    logic [9:0] hcount, vcount;
    logic       video_on, hsync, vsync, frame_start;
    logic [2:0] rout, gout, bout;
    logic [7:0] frame_cnt;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .pix_ce(pix_ce),
        .rin(rin), .gin(gin), .bin(bin),
        .hcount(hcount), .vcount(vcount), .video_on(video_on),
        .hsync(hsync), .vsync(vsync),
        .rout(rout), .gout(gout), .bout(bout),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 vga_clk = ~vga_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: p is the linear pixel index within the frame currently presented
    int   p;
    logic exp_hs, exp_vs, exp_fs;
    int   exp_r, exp_g, exp_b, exp_fc;
    int   frames_done, fs_seen;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t p=%0d)", tag, got, exp, $time, p);
        end
    endtask

    task automatic model_reset();
        p = 0; exp_hs = ~POL; exp_vs = ~POL; exp_fs = 1'b0;
        exp_r = 0; exp_g = 0; exp_b = 0; exp_fc = 0;
    endtask

    task automatic check_all();
        int h, v;
        h = p % HT;
        v = p / HT;
        check_val("hcount", int'(hcount), h);
        check_val("vcount", int'(vcount), v);
        check_val("video_on", int'(video_on), int'(h < HV && v < VV));
        check_val("hsync", int'(hsync), int'(exp_hs));
        check_val("vsync", int'(vsync), int'(exp_vs));
        check_val("rout", int'(rout), exp_r);
        check_val("gout", int'(gout), exp_g);
        check_val("bout", int'(bout), exp_b);
        check_val("frame_start", int'(frame_start), int'(exp_fs));
        check_val("frame_cnt", int'(frame_cnt), exp_fc);
    endtask

    // One vga_clk cycle: apply inputs, advance model at the edge, check 1ns later
    task automatic step(input logic ce, input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
        int h, v;
        pix_ce = ce; rin = r; gin = g; bin = b;
        @(posedge vga_clk);
        h = p % HT;
        v = p / HT;
        if (reset) begin
            model_reset();
        end else if (ce) begin
            exp_hs = (h >= HV + HF && h < HV + HF + HS) ? POL : ~POL;
            exp_vs = (v >= VV + VF && v < VV + VF + VS) ? POL : ~POL;
            exp_r  = (h < HV && v < VV) ? int'(r) : 0;
            exp_g  = (h < HV && v < VV) ? int'(g) : 0;
            exp_b  = (h < HV && v < VV) ? int'(b) : 0;
            exp_fs = (p == 0);
            if (p == FT - 1) begin
                exp_fc = (exp_fc + 1) % 256;
                frames_done++;
            end
            p = (p + 1) % FT;
        end else begin
            exp_fs = 1'b0;
        end
        #1;
        if (frame_start === 1'b1) fs_seen++;
        check_all();
    endtask

    task automatic rand_step(input int ce_pct);
        step(($urandom_range(99) < ce_pct), 3'($urandom), 3'($urandom), 3'($urandom));
    endtask

    // Asynchronous reset mid-cycle, held a few cycles, released away from the edge
    task automatic do_reset(input int hold);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        for (int i = 0; i < hold; i++) rand_step(50);
        reset = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        int guard;
        model_reset();
        frames_done = 0;
        fs_seen = 0;
        repeat (2) @(posedge vga_clk);
        #1;
        check_all();
        reset = 1'b0;

        // Constant enable, white input, two full frames
        for (int i = 0; i < 2 * FT; i++) step(1'b1, 3'b111, 3'b111, 3'b111);

        // Alternating enable: outputs must hold on idle cycles
        for (int i = 0; i < 2 * FT; i++) step(1'(i % 2 == 0), 3'($urandom), 3'($urandom), 3'($urandom));

        // Random enable and colour, with occasional random resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(699) == 0) do_reset($urandom_range(3));
            else rand_step(60);
        end

        // Directed reset at a known mid-frame position
        guard = 0;
        while (p != 4 * HT + 7 && guard < 2 * FT) begin
            step(1'b1, 3'd5, 3'd2, 3'd6);
            guard++;
        end
        check_val("reach_pos", p, 4 * HT + 7);
        do_reset(2);

        // 256 complete frames: counter wraps and one start pulse per frame
        frames_done = 0;
        fs_seen = 0;
        guard = 0;
        while (frames_done < 256 && guard < 60000) begin
            rand_step(90);
            guard++;
        end
        check_val("frames_done", frames_done, 256);
        check_val("fs_pulses", fs_seen, 256);
        check_val("frame_cnt_wrap", int'(frame_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL provide parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL provide parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 SHALL provide parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-004 SHALL provide parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 SHALL provide parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 SHALL provide parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 SHALL provide parameter V_SYNC, default 2, vsync pulse width in lines.
REQ-008 SHALL provide parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 SHALL provide parameter SYNC_POL, default 0, sync active level (0 = active-low).
REQ-010 SHALL have port vga_clk  in  1  system clock, rising edge.
REQ-011 SHALL have port reset  in  1  reset; asynchronous, active-high.
REQ-012 SHALL have port pix_ce  in  1  pixel clock enable; one pixel advances per vga_clk cycle with pix_ce=1.
REQ-013 SHALL have ports rin, gin, bin  in  3 each  pixel colour from source, valid in the cycle addressed by hcount/vcount.
REQ-014 SHALL have ports hcount, vcount  out  10 each  current pixel coordinates (pixel request address).
REQ-015 SHALL have port video_on  out  1  high when hcount<H_VISIBLE and vcount<V_VISIBLE.
REQ-016 SHALL have ports hsync, vsync  out  1 each  registered sync outputs at SYNC_POL polarity.
REQ-017 SHALL have ports rout, gout, bout  out  3 each  registered colour to DAC, aligned with hsync/vsync.
REQ-018 SHALL have port frame_start  out  1  single vga_clk pulse at start of each frame.
REQ-019 SHALL have port frame_cnt  out  8  completed-frame counter.

Function
REQ-020 H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525).
REQ-021 With pix_ce=1: hcount increments by 1; at H_TOTAL-1 wraps to 0 and vcount increments; vcount at V_TOTAL-1 with hcount wrap returns to 0.
REQ-022 With pix_ce=0: all counters, registered outputs, and frame_cnt hold; frame_start SHALL be 0.
REQ-023 video_on, hcount, vcount SHALL be combinational from the counters (stage 0).
REQ-024 Sync active region: hcount in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (default 656..751); vcount in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (default 490..491).
REQ-025 hsync, vsync, rout/gout/bout SHALL be registered on pix_ce from stage-0 values: one pix_ce cycle latency, mutually aligned.
REQ-026 Registered colour SHALL be rin/gin/bin when video_on=1, else 3'b000 (blanking forced regardless of inputs).
REQ-027 Sync output level = SYNC_POL when in active region, ~SYNC_POL otherwise.
REQ-028 frame_start SHALL pulse high for exactly one vga_clk cycle, registered, in the cycle after a pix_ce=1 cycle where hcount=0 and vcount=0.
REQ-029 frame_cnt SHALL increment on the pix_ce cycle where hcount=H_TOTAL-1 and vcount=V_TOTAL-1; wraps 255->0.
REQ-030 Counter widths SHALL be 10 bits; parameters with H_TOTAL or V_TOTAL >1024 are unsupported.
REQ-031 Counter state outside legal range (not reachable post-reset) SHALL recover to 0 at next pix_ce.

Reset
REQ-032 Reset asserted SHALL immediately force hcount=0, vcount=0, hsync=vsync=~SYNC_POL, rout=gout=bout=0, frame_start=0, frame_cnt=0.
REQ-033 Reset mid-frame SHALL abort the frame; after release the first pix_ce cycle presents pixel (0,0) and first frame_start follows it.
REQ-034 Reset takes precedence over pix_ce.

Verification
REQ-035 Reset, then pix_ce=1 constant, rin=gin=bin=3'b111 -> rout=7 for exactly 640 cycles per line; hsync low 96 cycles, first low one cycle after hcount=656.
REQ-036 Full frame with defaults -> 525 hsync pulses per vsync period; vsync low exactly 2x800 = 1600 cycles starting one cycle after (hcount,vcount)=(0,490).
REQ-037 pix_ce toggling 1/0 each cycle -> line period 1600 vga_clk cycles; all outputs stable during pix_ce=0 cycles; frame_start still one vga_clk wide.
REQ-038 Drive rin=5 during blanking (hcount=700) -> rout=0 one cycle later.
REQ-039 Run 256 frames -> frame_cnt returns 0; 256 frame_start pulses counted.
REQ-040 Assert reset at (hcount,vcount)=(300,200) -> outputs at reset values same cycle; after release hcount=0, vcount=0, frame_cnt=0.
